// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width: enough to count 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cond_negate.sv
// Two's-complement negation of x when en is set, pass-through otherwise.
module cond_negate #(
  parameter int w = 8
) (
  input  logic [w-1:0] x,
  input  logic         en,
  output logic [w-1:0] y
);

  assign y = en ? (~x + w'(1)) : x;

endmodule

// File: rtl/seq_signed_or_unsigned_mul.sv
// Iterative shift-add multiplier, one multiplier bit per clock, with
// per-operation signed/unsigned select and valid/ready on both sides.
module seq_signed_or_unsigned_mul
  import mul_pkg::*;
#(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           arg_vld,
  output logic           arg_rdy,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  input  logic           sign,
  output logic           res_vld,
  input  logic           res_rdy,
  output logic [2*n-1:0] res
);

  localparam int CW = cnt_width(n);

  state_t state_q, state_d;

  logic [2*n-1:0] mcand_q;
  logic [2*n-1:0] acc_q;
  logic [2*n-1:0] res_q;
  logic [n-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;
  logic           neg_q;

  logic [n-1:0]   a_mag;
  logic [n-1:0]   b_mag;
  logic [2*n-1:0] acc_sum;
  logic [2*n-1:0] res_fin;
  logic           accept;
  logic           last_bit;

  // Magnitudes of the operands; -2^(n-1) negates to 2^(n-1), still n bits.
  cond_negate #(.w(n)) u_neg_a (
    .x  (a),
    .en (sign & a[n-1]),
    .y  (a_mag)
  );

  cond_negate #(.w(n)) u_neg_b (
    .x  (b),
    .en (sign & b[n-1]),
    .y  (b_mag)
  );

  assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_bit = (cnt_q == CW'(n - 1));
  assign accept   = arg_vld & arg_rdy;

  // Sign correction applies to the final sum, folded into the DONE load.
  cond_negate #(.w(2*n)) u_neg_res (
    .x  (acc_sum),
    .en (neg_q),
    .y  (res_fin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    arg_rdy = 1'b0;
    res_vld = 1'b0;
    unique case (state_q)
      IDLE: begin
        arg_rdy = 1'b1;
        if (arg_vld) state_d = RUN;
      end
      RUN: begin
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        res_vld = 1'b1;
        if (res_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      res_q    <= '0;
    end else if (accept) begin
      mcand_q  <= {{n{1'b0}}, a_mag};
      mplier_q <= b_mag;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= sign & (a[n-1] ^ b[n-1]);
    end else if (state_q == RUN) begin
      acc_q    <= acc_sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (last_bit) res_q <= res_fin;
    end
  end

  assign res = res_q;

endmodule
